proc_ctrl_fsm: RTL and testbench

Multi-cycle control unit for the 16-bit simple processor datapath. Captures a 9-bit instruction from `din`, then sequences the shared bus multiplexer (`din_en`, `gout`, `rout`), the register-file load enables, the A/G accumulator registers and the add/sub ALU over one to three execution steps. It sits beside the bus mux and register file, and drives every select and enable in the datapath. It raises `done` on the final step of each instruction.

---
 rtl/proc_ctrl_fsm.sv | 157 +++++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm: multi-cycle control unit for the 16-bit simple processor.
// Captures a 9-bit instruction (III XXX YYY) from din[15:7] and sequences the
// bus mux selects, register-file load enables, A/G loads and the add/sub ALU
// over one to three execution steps.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   T0    | fetch / idle; IR loads din[15:7] when run is high
//   T1    | first execution step (single-step ops complete here)
//   T2    | add/sub: second operand onto bus, G loads
//   T3    | add/sub: G onto bus, result written to Rx
module proc_ctrl_fsm #(
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [15:0]     din,
  input  logic            g_nz,
  output logic            ir_in,
  output logic            din_en,
  output logic            gout,
  output logic [2:0]      rout,
  output logic [NREG-1:0] rin,
  output logic            ain,
  output logic            gin,
  output logic            addsub,
  output logic            done,
  output logic            busy
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  state_t      state_q, state_d;
  logic [8:0]  ir_q, ir_d;
  logic [2:0]  op, rx, ry;
  logic        is_alu;
  logic [NREG-1:0] rx_onehot;

  // The immediate field of din is consumed by the datapath, not by control.
  logic unused_din_low;
  assign unused_din_low = ^din[6:0];

  assign op     = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];
  assign is_alu = (op == OP_ADD) || (op == OP_SUB);

  // One-hot decode of Rx; register numbers beyond NREG select nothing.
  always_comb begin
    rx_onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      rx_onehot[i] = (int'(rx) == i);
    end
  end

  // Next-state and IR capture; run only matters in T0.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      T0: begin
        if (run) begin
          state_d = T1;
          ir_d    = din[15:7];
        end
      end
      T1:      state_d = is_alu ? T2 : T0;
      T2:      state_d = T3;
      T3:      state_d = T0;
      default: state_d = T0;
    endcase
  end

  // State and IR registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Output decode of state and IR; everything is forced low while reset is
  // held so that even a run request cannot strobe ir_in during reset.
  always_comb begin
    ir_in  = 1'b0;
    din_en = 1'b0;
    gout   = 1'b0;
    rout   = 3'b000;
    rin    = '0;
    ain    = 1'b0;
    gin    = 1'b0;
    addsub = 1'b0;
    done   = 1'b0;
    busy   = 1'b0;
    if (!reset) begin
      busy = (state_q != T0);
      case (state_q)
        T0: ir_in = run;
        T1: begin
          case (op)
            OP_MV: begin
              rout = ry;
              rin  = rx_onehot;
              done = 1'b1;
            end
            OP_MVI: begin
              din_en = 1'b1;
              rin    = rx_onehot;
              done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              rout = rx;
              ain  = 1'b1;
            end
            OP_MVNZ: begin
              rout = ry;
              rin  = g_nz ? rx_onehot : '0;
              done = 1'b1;
            end
            default: done = 1'b1;
          endcase
        end
        T2: begin
          if (is_alu) begin
            rout   = ry;
            gin    = 1'b1;
            addsub = op[0];
          end
        end
        T3: begin
          if (is_alu) begin
            gout = 1'b1;
            rin  = rx_onehot;
            done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Self-checking bench for proc_ctrl_fsm: table of instructions with the
// expected output word per step, plus hand-written reset / back-to-back runs.
module tb_proc_ctrl_fsm;

  localparam int NREG = 8;
  localparam int NV   = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic            run;
  logic [15:0]     din;
  logic            g_nz;
  logic            ir_in, din_en, gout, ain, gin, addsub, done, busy;
  logic [2:0]      rout;
  logic [NREG-1:0] rin;

  // {ir_in, din_en, gout, rout[2:0], rin[7:0], ain, gin, addsub, done, busy}
  typedef logic [18:0] obs_t;

  typedef struct {
    string          name;
    logic [8:0]     ir;
    logic           gnz;
    int             nsteps;
    logic [2:0][18:0] exp;
  } vec_t;

  vec_t tbl [NV];
  obs_t act;
  int   errors = 0;
  int   checks = 0;
  logic watch  = 1'b0;
  logic rin_seen = 1'b0;

  proc_ctrl_fsm #(.NREG(NREG)) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .din    (din),
    .g_nz   (g_nz),
    .ir_in  (ir_in),
    .din_en (din_en),
    .gout   (gout),
    .rout   (rout),
    .rin    (rin),
    .ain    (ain),
    .gin    (gin),
    .addsub (addsub),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  assign act = {ir_in, din_en, gout, rout, rin, ain, gin, addsub, done, busy};

  always @(posedge clk or negedge clk) begin
    if (watch && rin != '0) rin_seen = 1'b1;
  end

  function automatic obs_t mk(input logic ii, input logic de, input logic go,
                              input logic [2:0] ro, input logic [7:0] ri,
                              input logic a, input logic g, input logic asb,
                              input logic dn, input logic bz);
    return {ii, de, go, ro, ri, a, g, asb, dn, bz};
  endfunction

  task automatic chk(input string name, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int k, input string name, input logic [8:0] ir,
                         input logic gnz, input int n,
                         input obs_t e0, input obs_t e1, input obs_t e2);
    tbl[k].name   = name;
    tbl[k].ir     = ir;
    tbl[k].gnz    = gnz;
    tbl[k].nsteps = n;
    tbl[k].exp[0] = e0;
    tbl[k].exp[1] = e1;
    tbl[k].exp[2] = e2;
  endtask

  obs_t zero_o, t0run_o, nop_o;

  initial begin
    zero_o  = mk(0, 0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 0);
    t0run_o = mk(1, 0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 0);
    nop_o   = mk(0, 0, 0, 3'd0, 8'h00, 0, 0, 0, 1, 1);

    add_vec(0, "mvi_r0", 9'b001_000_000, 1'b0, 1,
            mk(0, 1, 0, 3'd0, 8'h01, 0, 0, 0, 1, 1), zero_o, zero_o);
    add_vec(1, "mv_r2_r5", 9'b000_010_101, 1'b0, 1,
            mk(0, 0, 0, 3'd5, 8'h04, 0, 0, 0, 1, 1), zero_o, zero_o);
    add_vec(2, "sub_r1_r6", 9'b011_001_110, 1'b0, 3,
            mk(0, 0, 0, 3'd1, 8'h00, 1, 0, 0, 0, 1),
            mk(0, 0, 0, 3'd6, 8'h00, 0, 1, 1, 0, 1),
            mk(0, 0, 1, 3'd0, 8'h02, 0, 0, 0, 1, 1));
    add_vec(3, "mvnz_gnz0", 9'b100_100_000, 1'b0, 1,
            mk(0, 0, 0, 3'd0, 8'h00, 0, 0, 0, 1, 1), zero_o, zero_o);
    add_vec(4, "mvnz_gnz1", 9'b100_100_000, 1'b1, 1,
            mk(0, 0, 0, 3'd0, 8'h10, 0, 0, 0, 1, 1), zero_o, zero_o);
    add_vec(5, "add_r3_r3", 9'b010_011_011, 1'b0, 3,
            mk(0, 0, 0, 3'd3, 8'h00, 1, 0, 0, 0, 1),
            mk(0, 0, 0, 3'd3, 8'h00, 0, 1, 0, 0, 1),
            mk(0, 0, 1, 3'd0, 8'h08, 0, 0, 0, 1, 1));
    add_vec(6, "nop_111", 9'b111_010_011, 1'b1, 1, nop_o, zero_o, zero_o);
    add_vec(7, "nop_101", 9'b101_111_111, 1'b1, 1, nop_o, zero_o, zero_o);
    add_vec(8, "mvi_r7", 9'b001_111_000, 1'b0, 1,
            mk(0, 1, 0, 3'd0, 8'h80, 0, 0, 0, 1, 1), zero_o, zero_o);

    // Reset with run already high: outputs must all be low.
    reset = 1'b1;
    run   = 1'b1;
    din   = 16'hE000;
    g_nz  = 1'b0;
    #12;
    chk("reset_state", zero_o);

    // Release with run held high: first edge captures a NOP, then an add
    // follows back-to-back; run toggles during the add's T1..T3.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("b2b_first_fetch", t0run_o);
    @(posedge clk); #1;
    din = {9'b010_010_101, 7'd0};
    @(negedge clk);
    chk("b2b_nop_T1", nop_o);
    @(negedge clk);
    chk("b2b_add_fetch", t0run_o);
    @(posedge clk); #1;
    run = 1'b0;
    @(negedge clk);
    chk("b2b_add_T1", mk(0, 0, 0, 3'd2, 8'h00, 1, 0, 0, 0, 1));
    @(posedge clk); #1;
    run = 1'b1;
    @(negedge clk);
    chk("b2b_add_T2", mk(0, 0, 0, 3'd5, 8'h00, 0, 1, 0, 0, 1));
    @(posedge clk); #1;
    run = 1'b0;
    @(negedge clk);
    chk("b2b_add_T3", mk(0, 0, 1, 3'd0, 8'h04, 0, 0, 0, 1, 1));
    @(negedge clk);
    chk("b2b_idle", zero_o);

    // Table-driven single instructions. run stays high in T1 and T3 to show
    // it is ignored; din[15:7] changes after capture to catch an IR reload.
    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      din  = {tbl[k].ir, 7'd0};
      run  = 1'b1;
      g_nz = tbl[k].gnz;
      @(negedge clk);
      chk($sformatf("%s:T0", tbl[k].name), t0run_o);
      for (int s = 0; s < tbl[k].nsteps; s++) begin
        @(posedge clk); #1;
        run = (s % 2 == 0);
        din = (s == 0) ? 16'h1234 : 16'hFF80;
        @(negedge clk);
        chk($sformatf("%s:T%0d", tbl[k].name, s + 1), tbl[k].exp[s]);
      end
      @(posedge clk); #1;
      run = 1'b0;
      @(negedge clk);
      chk($sformatf("%s:idle", tbl[k].name), zero_o);
    end

    // Reset during T2 of an add: outputs drop at once, no write-back ever.
    @(posedge clk); #1;
    din = {9'b010_011_011, 7'd0};
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_T2", mk(0, 0, 0, 3'd3, 8'h00, 0, 1, 0, 0, 1));
    #2;
    watch = 1'b1;
    reset = 1'b1;
    #1;
    chk("abort_async", zero_o);
    @(posedge clk); #1;
    chk("abort_held", zero_o);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_after_%0d", c), zero_o);
    end
    watch = 1'b0;
    checks++;
    if (rin_seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_rin: got rin pulse=%b expected 0", rin_seen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
